// File: rtl/serial_word_rx.sv
// serial_word_rx: rebuilds MSB-first serial words into a DEPTH-word FIFO.
// Ports: clk/reset_n, serial_in/bit_valid/frame_start in;
// word_data/word_valid/word_ready handshake; fifo_count, frame_error,
// overflow (sticky) with clear_overflow.
module serial_word_rx #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     frame_start,
  output logic [N-1:0]             word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_error,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   shreg;
  logic [N-1:0]   sh_nxt;
  logic           last;
  logic           push;
  logic           pop;
  logic           full;
  logic           push_ok;

  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;

  assign sh_nxt = {shreg[N-2:0], serial_in};
  assign last   = (cnt == CW'(N - 1));

  // Word completes on the Nth bit, never on a bit that restarts framing.
  assign push = bit_valid && (state == RECV)
              && !frame_start && last;

  assign word_valid = (count != '0);
  assign word_data  = mem[rptr];
  assign fifo_count = count;
  assign pop        = word_valid && word_ready;
  assign full       = (count == (AW+1)'(DEPTH));
  // A full FIFO still takes the word if the head leaves on this edge.
  assign push_ok    = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (frame_start) begin
              shreg <= sh_nxt;
              cnt   <= CW'(1);
              state <= RECV;
            end
          end
          RECV: begin
            shreg <= sh_nxt;
            if (frame_start) begin
              frame_error <= 1'b1;
              cnt         <= CW'(1);
            end else if (last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wptr] <= sh_nxt;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case (1'b1)
        (push_ok && !pop): count <= count + (AW+1)'(1);
        (pop && !push_ok): count <= count - (AW+1)'(1);
        default:           count <= count;
      endcase
      // Set wins over a same-cycle clear.
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: scoreboard bench for serial_word_rx.
// Expected words queued at drive time, compared on each handshake.
module tb_serial_word_rx;

  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          serial_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [N-1:0]  word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [2:0]    fifo_count;
  logic          frame_error;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  logic [N-1:0]  sb_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            fe_cnt = 0;
  int            fe_base;

  serial_word_rx #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .serial_in      (serial_in),
    .bit_valid      (bit_valid),
    .frame_start    (frame_start),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .fifo_count     (fifo_count),
    .frame_error    (frame_error),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: a pop happens on the next rising edge.
  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (reset_n && word_valid && word_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", {16'h0, word_data}, 32'hdead);
      end else begin
        chk("word", {16'h0, word_data}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w,
                           input int gap,
                           input bit exp);
    for (int i = N - 1; i >= 0; i--) begin
      if (gap > 0 && i != N - 1) begin
        repeat ($urandom_range(0, gap)) tick();
      end
      if (i == 0 && exp) sb_q.push_back(w);
      send_bit(w[i], i == N - 1);
    end
  endtask

  task automatic drain(input string tag);
    word_ready = 1'b1;
    for (int k = 0; k < 40 && fifo_count != 0; k++) tick();
    chk(tag, {29'h0, fifo_count}, 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] w;
    #1;
    do_reset();
    chk("rst_valid", {31'h0, word_valid}, 32'h0);
    chk("rst_data",  {16'h0, word_data},  32'h0);
    chk("rst_count", {29'h0, fifo_count}, 32'h0);
    chk("rst_fe",    {31'h0, frame_error}, 32'h0);
    chk("rst_ov",    {31'h0, overflow},    32'h0);

    // Single word, consumer always ready.
    word_ready = 1'b1;
    send_word(16'hA5C3, 0, 1'b1);
    chk("single_valid", {31'h0, word_valid}, 32'h1);
    chk("single_cnt1",  {29'h0, fifo_count}, 32'h1);
    tick();
    chk("single_vlow",  {31'h0, word_valid}, 32'h0);
    chk("single_cnt0",  {29'h0, fifo_count}, 32'h0);

    // Gapped word followed immediately by a back-to-back word.
    fe_base = fe_cnt;
    send_word(16'h1234, 3, 1'b1);
    send_word(16'hFFFF, 0, 1'b1);
    repeat (3) tick();
    chk("b2b_fe", fe_cnt - fe_base, 0);
    chk("b2b_sb", sb_q.size(), 0);

    // Overflow: fifth word dropped.
    word_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      w = N'(i);
      send_word(w, 0, i <= 4);
      if (i == 4) chk("ovf_pre", {31'h0, overflow}, 32'h0);
    end
    chk("ovf_cnt",  {29'h0, fifo_count}, 32'h4);
    chk("ovf_flag", {31'h0, overflow},   32'h1);
    drain("ovf_drain");
    word_ready = 1'b0;
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_clear", {31'h0, overflow}, 32'h0);

    // Full FIFO, push on the same edge as a pop.
    for (int i = 1; i <= 4; i++) begin
      w = 16'h0010 + N'(i);
      send_word(w, 0, 1'b1);
    end
    w = 16'h0015;
    for (int i = N - 1; i >= 1; i--) send_bit(w[i], i == N - 1);
    word_ready = 1'b1;
    sb_q.push_back(w);
    send_bit(w[0], 1'b0);
    word_ready = 1'b0;
    chk("full_cnt", {29'h0, fifo_count}, 32'h4);
    chk("full_ov",  {31'h0, overflow},   32'h0);
    drain("full_drain");

    // Framing fault: restart after six bits.
    fe_base = fe_cnt;
    for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0);
    w = 16'hBEEF;
    for (int i = N - 1; i >= 0; i--) begin
      if (i == 0) sb_q.push_back(w);
      send_bit(w[i], i == N - 1);
      if (i == N - 1) chk("fe_pulse", {31'h0, frame_error}, 32'h1);
      if (i == N - 2) chk("fe_low",   {31'h0, frame_error}, 32'h0);
    end
    repeat (2) tick();
    chk("fe_count", fe_cnt - fe_base, 1);
    chk("fe_sb", sb_q.size(), 0);

    // Asynchronous reset mid-word with words queued.
    word_ready = 1'b0;
    send_word(16'h1111, 0, 1'b0);
    send_word(16'h2222, 0, 1'b0);
    chk("rm_cnt2", {29'h0, fifo_count}, 32'h2);
    for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_valid", {31'h0, word_valid}, 32'h0);
    chk("rm_data",  {16'h0, word_data},  32'h0);
    chk("rm_count", {29'h0, fifo_count}, 32'h0);
    chk("rm_ov",    {31'h0, overflow},   32'h0);
    reset_n = 1'b1;
    tick();
    word_ready = 1'b1;
    send_word(16'h5A5A, 0, 1'b1);
    chk("rm_cnt1", {29'h0, fifo_count}, 32'h1);
    drain("rm_drain");
    repeat (2) tick();
    chk("final_sb", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
